// File: rtl/hv_enc_seq.sv
// hv_enc_seq - micro-sequencer for the hypervector encoder datapath.
//
// Fetches instructions from a host-loaded instruction memory. Each instruction
// either issues one opaque control word to the encoder or manages a hardware
// loop counter. Issue is held while an unconsumed query HV is pending and the
// instruction carries the wait flag.
//
// Instruction format (inst_i[31:30] = opcode):
//   00 OP         : [29] wait flag, [28:0] control word
//   01 LOOP_START : [LoopCountWidth-1:0] iteration count (0 behaves as 1)
//   10 LOOP_END
//   11 HALT
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   start_i, abort_i       run control (abort wins over start and instructions)
//   inst_addr_o, inst_i    instruction memory read port (combinational read)
//   qhv_valid_i            encoder query HV pending
//   ctrl_o, ctrl_valid_o   issued control word (zero when not issuing)
//   busy_o, done_o         running flag, one-cycle HALT pulse
//   error_o                sticky error, cleared by an accepted start
//
// Optional feature: define HV_ENC_SEQ_NESTED_LOOP_EN for a 2-deep loop stack;
// otherwise the loop stack is 1 deep.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no program running, pc held at 0
// S_RUN  | decoding/executing the instruction at pc
// S_WAIT | OP with wait flag stalled on qhv_valid_i, re-decoded each cycle

module hv_enc_seq #(
  parameter int InstMemDepth   = 64,
  parameter int InstWidth      = 32,
  parameter int CtrlWidth      = 29,
  parameter int LoopCountWidth = 8,
  parameter int PcWidth        = $clog2(InstMemDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [PcWidth-1:0]   inst_addr_o,
  input  logic [InstWidth-1:0] inst_i,
  input  logic                 qhv_valid_i,
  output logic [CtrlWidth-1:0] ctrl_o,
  output logic                 ctrl_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

`ifdef HV_ENC_SEQ_NESTED_LOOP_EN
  localparam logic [1:0] LoopDepth = 2'd2;
`else
  localparam logic [1:0] LoopDepth = 2'd1;
`endif

  localparam logic [1:0] OpOp        = 2'b00;
  localparam logic [1:0] OpLoopStart = 2'b01;
  localparam logic [1:0] OpLoopEnd   = 2'b10;

  localparam logic [PcWidth-1:0]        PcLast  = PcWidth'(InstMemDepth - 1);
  localparam logic [LoopCountWidth-1:0] CntOne  = LoopCountWidth'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PcWidth-1:0]        pc_q, pc_d;
  logic [1:0]                sp_q, sp_d;
  logic [PcWidth-1:0]        lpc_q [2];
  logic [PcWidth-1:0]        lpc_d [2];
  logic [LoopCountWidth-1:0] lcnt_q [2];
  logic [LoopCountWidth-1:0] lcnt_d [2];
  logic                      err_q, err_d;

  logic [1:0]                opcode;
  logic                      wait_flag;
  logic [LoopCountWidth-1:0] loop_n;
  logic                      top_idx;
  logic                      push_idx;
  logic                      advance;
  logic                      fault;

  assign opcode    = inst_i[InstWidth-1 -: 2];
  assign wait_flag = inst_i[CtrlWidth];
  assign loop_n    = inst_i[LoopCountWidth-1:0];

  // Stack pointer counts live entries; entry 1 only ever used when nested.
  assign top_idx  = (sp_q == 2'd2);
  assign push_idx = (sp_q == 2'd1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    sp_d         = sp_q;
    lpc_d        = lpc_q;
    lcnt_d       = lcnt_q;
    err_d        = err_q;
    ctrl_o       = '0;
    ctrl_valid_o = 1'b0;
    done_o       = 1'b0;
    advance      = 1'b0;
    fault        = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
      pc_d    = '0;
      sp_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pc_d = '0;
          if (start_i) begin
            err_d   = 1'b0;
            sp_d    = '0;
            state_d = S_RUN;
          end
        end
        S_RUN, S_WAIT: begin
          unique case (opcode)
            OpOp: begin
              if (wait_flag && qhv_valid_i) begin
                state_d = S_WAIT;
              end else begin
                ctrl_o       = inst_i[CtrlWidth-1:0];
                ctrl_valid_o = 1'b1;
                state_d      = S_RUN;
                advance      = 1'b1;
              end
            end
            OpLoopStart: begin
              if (sp_q == LoopDepth) begin
                fault = 1'b1;
              end else begin
                lpc_d[push_idx]  = pc_q + 1'b1;
                lcnt_d[push_idx] = (loop_n == '0) ? CntOne : loop_n;
                sp_d             = sp_q + 2'd1;
                advance          = 1'b1;
              end
            end
            OpLoopEnd: begin
              if (sp_q == 2'd0) begin
                fault = 1'b1;
              end else if (lcnt_q[top_idx] > CntOne) begin
                lcnt_d[top_idx] = lcnt_q[top_idx] - 1'b1;
                pc_d            = lpc_q[top_idx];
              end else begin
                sp_d    = sp_q - 2'd1;
                advance = 1'b1;
              end
            end
            default: begin
              done_o  = 1'b1;
              state_d = S_IDLE;
              pc_d    = '0;
              sp_d    = '0;
            end
          endcase

          // No wrap-around: stepping off the last word is an error, but an OP
          // sitting there still issues in its decode cycle.
          if (advance && (pc_q == PcLast)) begin
            fault = 1'b1;
          end else if (advance) begin
            pc_d = pc_q + 1'b1;
          end

          if (fault) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            pc_d    = '0;
            sp_d    = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          pc_d    = '0;
          sp_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      lpc_q   <= '{default: '0};
      lcnt_q  <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      lpc_q   <= lpc_d;
      lcnt_q  <= lcnt_d;
      err_q   <= err_d;
    end
  end

  assign inst_addr_o = pc_q;
  assign busy_o      = (state_q != S_IDLE);
  assign error_o     = err_q;

endmodule

// File: tb/tb_hv_enc_seq.sv
// Testbench for hv_enc_seq: directed program scenarios plus random programs,
// all checked cycle by cycle against an instruction-level interpreter that
// tracks only "running / not running", a pc and a loop stack queue.
// Honours HV_ENC_SEQ_NESTED_LOOP_EN the same way as the design.

module tb_hv_enc_seq;

  localparam int Depth = 64;
  localparam int IW    = 32;
  localparam int CW    = 29;
  localparam int LW    = 8;
  localparam int PW    = 6;

`ifdef HV_ENC_SEQ_NESTED_LOOP_EN
  localparam int StackDepth = 2;
`else
  localparam int StackDepth = 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          qhv_valid_i = 1'b0;
  logic [PW-1:0] inst_addr_o;
  logic [IW-1:0] inst_i;
  logic [CW-1:0] ctrl_o;
  logic          ctrl_valid_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  logic [31:0] mem [Depth];
  assign inst_i = mem[inst_addr_o];

  hv_enc_seq #(
    .InstMemDepth  (Depth),
    .InstWidth     (IW),
    .CtrlWidth     (CW),
    .LoopCountWidth(LW)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .inst_addr_o (inst_addr_o),
    .inst_i      (inst_i),
    .qhv_valid_i (qhv_valid_i),
    .ctrl_o      (ctrl_o),
    .ctrl_valid_o(ctrl_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_op(input bit w, input int unsigned c);
    return {2'b00, w, 29'(c)};
  endfunction
  function automatic logic [31:0] f_ls(input int unsigned n);
    return {2'b01, 22'd0, 8'(n)};
  endfunction
  function automatic logic [31:0] f_le();
    return {2'b10, 30'd0};
  endfunction
  function automatic logic [31:0] f_halt();
    return {2'b11, 30'd0};
  endfunction

  // Reference model state
  bit m_busy = 0;
  bit m_err  = 0;
  int m_pc   = 0;
  int stk_pc[$];
  int stk_cnt[$];

  // Observed DUT trace of the current program run
  int tr_valid[$];
  int tr_ctrl[$];
  int tr_done[$];
  int tr_busy[$];
  int tr_err[$];
  int tr_addr[$];

  int q_script[$];

  task automatic model_reset();
    m_busy = 0;
    m_err  = 0;
    m_pc   = 0;
    stk_pc.delete();
    stk_cnt.delete();
  endtask

  task automatic get_qv(input int pct, output logic v);
    if (q_script.size() > 0) v = q_script.pop_front() != 0;
    else v = ($urandom_range(99) < pct);
  endtask

  task automatic one_cycle(input logic st, input logic ab, input logic qv);
    logic [31:0] ins;
    bit adv, fail, ev, ed;
    int ec, n;
    @(negedge clk_i);
    start_i = st;
    abort_i = ab;
    qhv_valid_i = qv;
    #1;
    chk("inst_addr", inst_addr_o, m_pc);
    chk("busy", busy_o, m_busy);
    chk("error", error_o, m_err);
    tr_valid.push_back(int'(ctrl_valid_o));
    tr_ctrl.push_back(int'(ctrl_o));
    tr_done.push_back(int'(done_o));
    tr_busy.push_back(int'(busy_o));
    tr_err.push_back(int'(error_o));
    tr_addr.push_back(int'(inst_addr_o));

    ins = mem[m_pc];
    adv = 0; fail = 0; ev = 0; ed = 0; ec = 0;
    if (ab) begin
      m_busy = 0; m_pc = 0;
      stk_pc.delete(); stk_cnt.delete();
    end else if (!m_busy) begin
      if (st) begin
        m_err = 0; m_busy = 1; m_pc = 0;
        stk_pc.delete(); stk_cnt.delete();
      end
    end else begin
      case (ins[31:30])
        2'b00: begin
          if (!(ins[29] && qv)) begin
            ev = 1; ec = int'(ins[28:0]); adv = 1;
          end
        end
        2'b01: begin
          if (stk_pc.size() == StackDepth) fail = 1;
          else begin
            n = int'(ins[7:0]);
            stk_pc.push_back(m_pc + 1);
            stk_cnt.push_back((n == 0) ? 1 : n);
            adv = 1;
          end
        end
        2'b10: begin
          if (stk_pc.size() == 0) fail = 1;
          else if (stk_cnt[stk_cnt.size()-1] > 1) begin
            stk_cnt[stk_cnt.size()-1] = stk_cnt[stk_cnt.size()-1] - 1;
            m_pc = stk_pc[stk_pc.size()-1];
          end else begin
            void'(stk_pc.pop_back());
            void'(stk_cnt.pop_back());
            adv = 1;
          end
        end
        default: begin
          ed = 1; m_busy = 0; m_pc = 0;
          stk_pc.delete(); stk_cnt.delete();
        end
      endcase
      if (adv) begin
        if (m_pc + 1 >= Depth) fail = 1;
        else m_pc = m_pc + 1;
      end
      if (fail) begin
        m_err = 1; m_busy = 0; m_pc = 0;
        stk_pc.delete(); stk_cnt.delete();
      end
    end
    chk("ctrl_valid", ctrl_valid_o, ev);
    chk("ctrl", ctrl_o, ec);
    chk("done", done_o, ed);
  endtask

  task automatic run_prog(input int max_cyc, input int qpct, input int abort_at, input int start_pct);
    int k;
    logic qv;
    tr_valid.delete(); tr_ctrl.delete(); tr_done.delete();
    tr_busy.delete(); tr_err.delete(); tr_addr.delete();
    get_qv(qpct, qv);
    one_cycle(1'b1, 1'b0, qv);
    k = 1;
    while (m_busy && k < max_cyc) begin
      get_qv(qpct, qv);
      one_cycle(($urandom_range(99) < start_pct), (k == abort_at), qv);
      k++;
    end
    if (m_busy) begin
      chk("timeout", m_busy, 0);
      one_cycle(1'b0, 1'b1, 1'b0);
    end
    one_cycle(1'b0, 1'b0, 1'b0);
    q_script.delete();
  endtask

  function automatic int count_issues(input int c);
    int n = 0;
    foreach (tr_valid[i]) if (tr_valid[i] == 1 && tr_ctrl[i] == c) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (tr_done[i]) n += tr_done[i];
    return n;
  endfunction

  function automatic int first_done();
    foreach (tr_done[i]) if (tr_done[i] == 1) return i;
    return -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < Depth; i++) mem[i] = f_halt();
  endtask

  task automatic load_loop_prog();
    clear_mem();
    mem[0] = f_ls(3);
    mem[1] = f_op(0, 32'h5);
    mem[2] = f_le();
    mem[3] = f_halt();
  endtask

  initial begin
    clear_mem();
    #3;
    chk("rst_inst_addr", inst_addr_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_ctrl_valid", ctrl_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    #10 rst_ni = 1'b1;
    model_reset();

    // Straight-line program
    mem[0] = f_op(0, 32'h1);
    mem[1] = f_op(0, 32'h2);
    mem[2] = f_halt();
    run_prog(50, 0, -1, 0);
    chk("sl_valid1", tr_valid[1], 1);
    chk("sl_ctrl1", tr_ctrl[1], 1);
    chk("sl_valid2", tr_valid[2], 1);
    chk("sl_ctrl2", tr_ctrl[2], 2);
    chk("sl_done3", tr_done[3], 1);
    chk("sl_busy3", tr_busy[3], 1);
    chk("sl_busy4", tr_busy[4], 0);

    // Single loop: N*(B+1)+1 loop cycles after the start cycle, then HALT
    load_loop_prog();
    run_prog(100, 0, -1, 0);
    chk("loop_issues", count_issues(5), 3);
    chk("loop_halt_cycle", first_done(), 1 + 3 * (1 + 1) + 1);

    // Wait flag held off for 4 cycles
    clear_mem();
    mem[0] = f_op(0, 32'h3);
    mem[1] = f_op(1, 32'h9);
    mem[2] = f_halt();
    q_script = '{0, 0, 1, 1, 1, 1, 0};
    run_prog(50, 0, -1, 0);
    for (int i = 2; i <= 5; i++) chk("wait_hold", tr_valid[i], 0);
    chk("wait_issue", tr_valid[6], 1);
    chk("wait_ctrl", tr_ctrl[6], 9);
    chk("wait_addr_hold", tr_addr[6], 1);
    chk("wait_addr_adv", tr_addr[7], 2);
    chk("wait_done", tr_done[7], 1);

    // LOOP_END without a loop, then recovery
    clear_mem();
    mem[0] = f_le();
    run_prog(50, 0, -1, 0);
    chk("err_flag", tr_err[2], 1);
    chk("err_busy", tr_busy[2], 0);
    chk("err_no_done", count_done(), 0);
    mem[0] = f_op(0, 32'h1);
    run_prog(50, 0, -1, 0);
    chk("err_cleared", tr_err[1], 0);
    chk("err_recover_done", count_done(), 1);

    // Nested loops
    clear_mem();
    mem[0] = f_ls(2);
    mem[1] = f_ls(3);
    mem[2] = f_op(0, 32'h7);
    mem[3] = f_le();
    mem[4] = f_le();
    run_prog(200, 0, -1, 0);
`ifdef HV_ENC_SEQ_NESTED_LOOP_EN
    chk("nest_issues", count_issues(7), 6);
    chk("nest_done", count_done(), 1);
`else
    chk("nest_err", tr_err[3], 1);
    chk("nest_issues", count_issues(7), 0);
    chk("nest_done", count_done(), 0);
`endif

    // Abort inside the loop body, then rerun
    load_loop_prog();
    run_prog(100, 0, 4, 0);
    chk("abort_valid", tr_valid[4], 0);
    chk("abort_busy", tr_busy[5], 0);
    chk("abort_no_done", count_done(), 0);
    run_prog(100, 0, -1, 0);
    chk("abort_rerun_issues", count_issues(5), 3);
    chk("abort_rerun_done", count_done(), 1);

    // Running off the end of instruction memory
    for (int i = 0; i < Depth; i++) mem[i] = f_op(0, i + 1);
    run_prog(200, 0, -1, 0);
    chk("ovf_issues", count_issues(Depth), 1);
    chk("ovf_err", error_o, 1);
    chk("ovf_no_done", count_done(), 0);

    // Asynchronous reset mid-run
    load_loop_prog();
    tr_valid.delete();
    one_cycle(1'b1, 1'b0, 1'b0);
    one_cycle(1'b0, 1'b0, 1'b0);
    one_cycle(1'b0, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", inst_addr_o, 0);
    chk("arst_valid", ctrl_valid_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random programs
    for (int p = 0; p < 40; p++) begin
      int len, r, ab;
      clear_mem();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len - 1; i++) begin
        r = $urandom_range(99);
        if (r < 60)      mem[i] = f_op($urandom_range(99) < 30, $urandom);
        else if (r < 75) mem[i] = f_ls($urandom_range(0, 3));
        else if (r < 90) mem[i] = f_le();
        else             mem[i] = f_halt();
      end
      ab = ($urandom_range(99) < 20) ? $urandom_range(2, 30) : -1;
      run_prog(3000, 30, ab, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
